// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder sitting behind the MEM stage.
// Optional misalign detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    logic          op_wr;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          mis_q;

    logic          req;
    logic          accept;
    logic          enter_done;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          mis;
    logic          unused_bits;

    logic          sel_wr;
    logic [AW-1:0] sel_idx;
    logic [31:0]   sel_wdata;
    logic          sel_mis;

    logic [31:0]   mem [DEPTH];

    assign req    = mem_r_en | mem_w_en;
    assign accept = (state == IDLE) & req;
    assign offset = addr - 32'(BASE_ADDR);
    assign idx    = offset[AW+1:2];

    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = (addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // With zero wait states the commit happens on the accept edge, so the
    // live request must be used instead of the not-yet-latched copy.
    assign sel_wr    = (state == IDLE) ? mem_w_en : op_wr;
    assign sel_idx   = (state == IDLE) ? idx      : idx_q;
    assign sel_wdata = (state == IDLE) ? wdata    : wdata_q;
    assign sel_mis   = (state == IDLE) ? mis      : mis_q;

    assign enter_done = (state_nx == DONE) & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (WAIT_CYCLES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == DONE);
        freeze = req & ~ready;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (state == DONE) & mis_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(WAIT_CYCLES);
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            op_wr   <= mem_w_en;
            idx_q   <= idx;
            wdata_q <= wdata;
            mis_q   <= mis;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (enter_done & ~sel_wr) begin
            rdata <= sel_mis ? 32'h0 : mem[sel_idx];
        end
    end

    // Array is deliberately not cleared; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (~rst & enter_done & sel_wr & ~sel_mis) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level model plus directed vectors.
// Second instance exercises the zero-wait-state configuration.
module tb_dmem_responder;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;

    logic        r0 = 1'b0;
    logic        w0 = 1'b0;
    logic [31:0] addr0 = 32'd1024;
    logic [31:0] wdata0 = 32'd0;
    logic [31:0] rdata0;
    logic        ready0;
    logic        freeze0;

`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
    logic        misalign0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dmem_responder #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .freeze(freeze)
`ifdef DMEM_ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    dmem_responder #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0),
        .freeze(freeze0)
`ifdef DMEM_ALIGN_CHECK_EN
        , .misalign(misalign0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'd1024) / 32'd4) % 64;
    endfunction

    function automatic bit is_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a % 4) != 0;
`else
        return (a % 4) != 0 && 1'b0;
`endif
    endfunction

    // Model: an accepted request completes WAIT+1 cycles later; the responder
    // is busy until that completion cycle has passed.
    logic [31:0] mem_m [64];
    logic [31:0] exp_rdata = 32'd0;
    bit          pend = 0;
    int          done_cyc = 0;
    bit          m_wr, m_mis;
    int          m_idx;
    logic [31:0] m_wd;
    bit          prev_rst = 0;
    bit          model_ok = 0;

    always @(negedge clk) begin
        bit busy;
        bit exp_ready;
        if (prev_rst) begin
            pend = 0;
            exp_rdata = 32'd0;
            model_ok = 1;
        end
        busy = pend;
        exp_ready = 0;
        if (pend && cyc == done_cyc) begin
            exp_ready = 1;
            pend = 0;
            if (m_wr) begin
                if (!m_mis) mem_m[m_idx] = m_wd;
            end else begin
                exp_rdata = m_mis ? 32'd0 : mem_m[m_idx];
            end
        end
        if (model_ok) begin
            chk("ready", {31'd0, ready}, {31'd0, exp_ready});
            chk("freeze", {31'd0, freeze}, {31'd0, (r_en | w_en) & ~exp_ready});
            chk("rdata", rdata, exp_rdata);
`ifdef DMEM_ALIGN_CHECK_EN
            chk("misalign", {31'd0, misalign}, {31'd0, exp_ready & m_mis});
`endif
        end
        if (model_ok && !busy && !rst && (r_en || w_en)) begin
            pend = 1;
            done_cyc = cyc + W + 1;
            m_wr = w_en;
            m_idx = widx(addr);
            m_wd = wdata;
            m_mis = is_mis(addr);
        end
        prev_rst = rst;
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit hold,
                          input string tag);
        int t0;
        int fz;
        int lat;
        bit got;
        @(posedge clk);
        #1;
        r_en = rd;
        w_en = wr;
        addr = a;
        wdata = d;
        t0 = cyc;
        fz = 0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (freeze) fz++;
            if (ready) begin
                got = 1;
                lat = cyc - t0;
            end else if (!hold) begin
                @(posedge clk);
                #1;
                r_en = 0;
                w_en = 0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ready within 20 cycles", tag);
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(W + 1));
            if (hold) chk({tag, " freeze cycles"}, 32'(fz), 32'(W + 1));
        end
        @(posedge clk);
        #1;
        r_en = 0;
        w_en = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset rdata", rdata, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd0);

        access(0, 1, 32'd1028, 32'hDEADBEEF, 1, "w1028");
        access(1, 0, 32'd1028, 32'd0, 1, "r1028");
        chk("read 1028", rdata, 32'hDEADBEEF);

        access(0, 1, 32'd1024, 32'h11111111, 1, "w1024");
        access(1, 0, 32'd1280, 32'd0, 1, "r1280");
        chk("alias 1280", rdata, 32'h11111111);

        access(1, 1, 32'd1032, 32'hA5A5A5A5, 1, "both1032");
        chk("both keeps rdata", rdata, 32'h11111111);
        access(1, 0, 32'd1032, 32'd0, 1, "r1032");
        chk("read 1032", rdata, 32'hA5A5A5A5);

        access(0, 1, 32'd1036, 32'h0, 1, "w1036z");
        @(posedge clk);
        #1;
        w_en = 1;
        addr = 32'd1036;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        w_en = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no ready after reset", {31'd0, ready}, 32'd0);
        end
        chk("rdata after reset", rdata, 32'd0);
        access(1, 0, 32'd1036, 32'd0, 1, "r1036");
        chk("aborted write", rdata, 32'h0);

        access(0, 1, 32'd1040, 32'h13579BDF, 0, "w1040drop");
        access(1, 0, 32'd1040, 32'd0, 0, "r1040drop");
        chk("dropped enables", rdata, 32'h13579BDF);

`ifdef DMEM_ALIGN_CHECK_EN
        access(0, 1, 32'd1025, 32'h12345678, 1, "w1025mis");
        access(1, 0, 32'd1024, 32'd0, 1, "r1024");
        chk("misaligned write suppressed", rdata, 32'h11111111);
`else
        access(1, 0, 32'd1030, 32'd0, 1, "r1030");
        chk("low bits ignored", rdata, 32'hDEADBEEF);
`endif

        @(posedge clk);
        #1;
        w0 = 1;
        addr0 = 32'd1024;
        wdata0 = 32'h55;
        @(negedge clk);
        chk("w0 accept ready", {31'd0, ready0}, 32'd0);
        chk("w0 accept freeze", {31'd0, freeze0}, 32'd1);
        @(negedge clk);
        chk("w0 done ready", {31'd0, ready0}, 32'd1);
        chk("w0 done freeze", {31'd0, freeze0}, 32'd0);
        @(posedge clk);
        #1;
        w0 = 0;
        r0 = 1;
        @(negedge clk);
        chk("r0 accept1 ready", {31'd0, ready0}, 32'd0);
        chk("r0 accept1 freeze", {31'd0, freeze0}, 32'd1);
        @(negedge clk);
        chk("r0 done1 ready", {31'd0, ready0}, 32'd1);
        chk("r0 done1 rdata", rdata0, 32'h55);
        @(negedge clk);
        chk("r0 accept2 ready", {31'd0, ready0}, 32'd0);
        @(negedge clk);
        chk("r0 done2 ready", {31'd0, ready0}, 32'd1);
        @(posedge clk);
        #1;
        r0 = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
